mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_pkg.sv | 15 +
 rtl/arb_rr_pick.sv | 21 ++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: memory commands
// and the data-memory arbiter state encoding.
package cpu_pkg;

  localparam logic [7:0] CMD_READ  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way requester picker: round-robin on a tie
// when fair, otherwise port 0 wins the tie.
module arb_rr_pick (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  input  logic fair_i,
  output logic gnt_o
);

  // Choose the port index to own the next transaction
  always_comb begin
    gnt_o = 1'b0;
    if (req0_i && req1_i) begin
      gnt_o = fair_i ? ~last_i : 1'b0;
    end else if (req1_i) begin
      gnt_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: one 4-cycle
// transaction (IDLE/GRANT/ACCESS/DONE) at a time.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m0_req,
  input  logic [7:0] m0_cmd,
  input  logic [7:0] m0_addr,
  input  logic [7:0] m0_wdata,
  output logic       m0_gnt,
  output logic [7:0] m0_rdata,
  output logic       m0_done,
  input  logic       m1_req,
  input  logic [7:0] m1_cmd,
  input  logic [7:0] m1_addr,
  input  logic [7:0] m1_wdata,
  output logic       m1_gnt,
  output logic [7:0] m1_rdata,
  output logic       m1_done,
  output logic [7:0] mem_cmd,
  output logic [7:0] mem_addr,
  inout  wire  [7:0] mem_data
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata0_q, rdata0_d;
  logic [7:0] rdata1_q, rdata1_d;
  logic       pick;
  logic       busy;
  logic       on_bus;
  logic       wr_drive;

  arb_rr_pick u_pick (
    .req0_i (m0_req),
    .req1_i (m1_req),
    .last_i (last_q),
    .fair_i (FAIR != 0),
    .gnt_o  (pick)
  );

  // State and latched transaction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cmd_q    <= 8'h00;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Next state, owner latch and read capture
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d = GRANT;
          owner_d = pick;
          last_d  = pick;
          cmd_d   = pick ? m1_cmd : m0_cmd;
          addr_d  = pick ? m1_addr : m0_addr;
          wdata_d = pick ? m1_wdata : m0_wdata;
        end
      end
      GRANT: state_d = ACCESS;
      ACCESS: begin
        state_d = DONE;
        if (cmd_q == CMD_READ) begin
          if (owner_q) rdata1_d = mem_data;
          else         rdata0_d = mem_data;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign on_bus   = (state_q == GRANT) ||
                    (state_q == ACCESS);
  assign wr_drive = (state_q == ACCESS) &&
                    (cmd_q == CMD_WRITE);

  assign m0_gnt   = busy && !owner_q;
  assign m1_gnt   = busy && owner_q;
  assign m0_done  = (state_q == DONE) && !owner_q;
  assign m1_done  = (state_q == DONE) && owner_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  assign mem_cmd  = on_bus ? cmd_q : 8'h00;
  assign mem_addr = on_bus ? addr_q : 8'h00;
  assign mem_data = wr_drive ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: FAIR=1 and
// FAIR=0 instances share stimulus and a memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       m0_req, m1_req;
  logic [7:0] m0_cmd, m0_addr, m0_wdata;
  logic [7:0] m1_cmd, m1_addr, m1_wdata;

  logic       m0_gnt, m1_gnt, m0_done, m1_done;
  logic [7:0] m0_rdata, m1_rdata, mem_cmd, mem_addr;
  wire  [7:0] mem_data;

  logic       f0_m0_gnt, f0_m1_gnt;
  logic       f0_m0_done, f0_m1_done;
  logic [7:0] f0_m0_rdata, f0_m1_rdata;
  logic [7:0] f0_mem_cmd, f0_mem_addr;
  wire  [7:0] f0_mem_data;

  logic       mem_drive_en;
  logic [7:0] mem_arr [256];

  int checks;
  int errors;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (mem_data[i]);
    pullup (f0_mem_data[i]);
  end

  assign mem_data =
    (mem_drive_en && mem_cmd == 8'h00) ?
    mem_arr[mem_addr] : 8'hzz;

  always @(posedge clk)
    if (rst_n && mem_cmd == 8'h01)
      mem_arr[mem_addr] <= mem_data;

  mem_arbiter #(.FAIR(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_cmd(m0_cmd),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
    .m0_done(m0_done),
    .m1_req(m1_req), .m1_cmd(m1_cmd),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
    .m1_done(m1_done),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_data(mem_data)
  );

  mem_arbiter #(.FAIR(0)) dut_f0 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_cmd(m0_cmd),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(f0_m0_gnt), .m0_rdata(f0_m0_rdata),
    .m0_done(f0_m0_done),
    .m1_req(m1_req), .m1_cmd(m1_cmd),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(f0_m1_gnt), .m1_rdata(f0_m1_rdata),
    .m1_done(f0_m1_done),
    .mem_cmd(f0_mem_cmd), .mem_addr(f0_mem_addr),
    .mem_data(f0_mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mutual exclusion of grants and done pulses
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (m0_gnt && m1_gnt) begin
        errors++;
        $display("FAIL excl_gnt: both grants high at %0t", $time);
      end
      checks++;
      if (m0_done && m1_done) begin
        errors++;
        $display("FAIL excl_done: both done high at %0t", $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({m0_gnt, m1_gnt, m0_done, m1_done} !== 4'b0) begin
      errors++;
      $display("FAIL rst_ctl: got %b want 0000",
               {m0_gnt, m1_gnt, m0_done, m1_done});
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== 16'h0000) begin
      errors++;
      $display("FAIL rst_rdata: got %h want 0000",
               {m0_rdata, m1_rdata});
    end
    checks++;
    if ({mem_cmd, mem_addr} !== 16'h0000) begin
      errors++;
      $display("FAIL rst_bus: got %h want 0000",
               {mem_cmd, mem_addr});
    end
    checks++;
    if (mem_data !== 8'hFF) begin
      errors++;
      $display("FAIL rst_data: got %h want FF (released)",
               mem_data);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: gnt %b%b want 00",
               m0_gnt, m1_gnt);
    end
  endtask

  task automatic test_write();
    m0_req = 1'b1; m0_cmd = 8'h01;
    m0_addr = 8'h10; m0_wdata = 8'hA5;
    step();
    checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL wr_gnt: gnt %b%b want 10",
               m0_gnt, m1_gnt);
    end
    checks++;
    if (mem_cmd !== 8'h01 || mem_addr !== 8'h10) begin
      errors++;
      $display("FAIL wr_bus: cmd %h addr %h want 01 10",
               mem_cmd, mem_addr);
    end
    checks++;
    if (mem_data !== 8'hFF) begin
      errors++;
      $display("FAIL wr_grant_data: got %h want FF", mem_data);
    end
    m0_wdata = 8'h11;
    step();
    checks++;
    if (mem_data !== 8'hA5 || m0_done !== 1'b0) begin
      errors++;
      $display("FAIL wr_access: data %h done %b want A5 0",
               mem_data, m0_done);
    end
    step();
    checks++;
    if (m0_done !== 1'b1 || mem_data !== 8'hFF) begin
      errors++;
      $display("FAIL wr_done: done %b data %h want 1 FF",
               m0_done, mem_data);
    end
    checks++;
    if (mem_cmd !== 8'h00 || mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL wr_done_bus: cmd %h addr %h want 00 00",
               mem_cmd, mem_addr);
    end
    m0_req = 1'b0;
    step();
    checks++;
    if (m0_done !== 1'b0 || m0_gnt !== 1'b0) begin
      errors++;
      $display("FAIL wr_idle: done %b gnt %b want 0 0",
               m0_done, m0_gnt);
    end
  endtask

  task automatic test_read();
    mem_drive_en = 1'b1;
    m1_req = 1'b1; m1_cmd = 8'h00; m1_addr = 8'h10;
    step();
    checks++;
    if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rd_gnt: gnt %b%b want 01",
               m0_gnt, m1_gnt);
    end
    step();
    step();
    checks++;
    if (m1_done !== 1'b1 || m1_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL rd_data: done %b rdata %h want 1 A5",
               m1_done, m1_rdata);
    end
    checks++;
    if (m0_rdata !== 8'h00) begin
      errors++;
      $display("FAIL rd_other: m0_rdata %h want 00", m0_rdata);
    end
    m1_req = 1'b0;
    mem_drive_en = 1'b0;
    step();
  endtask

  task automatic test_fairness();
    logic exp1;
    m0_req = 1'b1; m0_cmd = 8'h07; m0_addr = 8'h01;
    m1_req = 1'b1; m1_cmd = 8'h07; m1_addr = 8'h02;
    for (int i = 0; i < 4; i++) begin
      exp1 = i[0];
      step();
      checks++;
      if (m0_gnt !== !exp1 || m1_gnt !== exp1) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: gnt %b%b want %b%b",
                 i, m0_gnt, m1_gnt, !exp1, exp1);
      end
      checks++;
      if (f0_m0_gnt !== 1'b1 || f0_m1_gnt !== 1'b0) begin
        errors++;
        $display("FAIL fix_gnt[%0d]: gnt %b%b want 10",
                 i, f0_m0_gnt, f0_m1_gnt);
      end
      step();
      step();
      checks++;
      if (m0_done !== !exp1 || m1_done !== exp1) begin
        errors++;
        $display("FAIL rr_done[%0d]: done %b%b want %b%b",
                 i, m0_done, m1_done, !exp1, exp1);
      end
      checks++;
      if (f0_m0_done !== 1'b1 || f0_m1_done !== 1'b0) begin
        errors++;
        $display("FAIL fix_done[%0d]: done %b%b want 10",
                 i, f0_m0_done, f0_m1_done);
      end
      step();
      checks++;
      if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle[%0d]: gnt %b%b want 00",
                 i, m0_gnt, m1_gnt);
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
  endtask

  task automatic test_reset_abort();
    m0_req = 1'b1; m0_cmd = 8'h01;
    m0_addr = 8'h20; m0_wdata = 8'h3C;
    step();
    step();
    checks++;
    if (mem_data !== 8'h3C) begin
      errors++;
      $display("FAIL abort_pre: data %h want 3C", mem_data);
    end
    m0_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_data !== 8'hFF) begin
      errors++;
      $display("FAIL abort_release: data %h want FF", mem_data);
    end
    checks++;
    if (m0_gnt !== 1'b0 || m0_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_ctl: gnt %b done %b want 0 0",
               m0_gnt, m0_done);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (m0_done !== 1'b0 || m0_gnt !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: gnt %b done %b want 0 0",
               m0_gnt, m0_done);
    end
    mem_drive_en = 1'b1;
    m0_req = 1'b1; m0_cmd = 8'h00; m0_addr = 8'h10;
    step();
    checks++;
    if (m0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL post_gnt: gnt %b want 1", m0_gnt);
    end
    m0_req = 1'b0;
    m0_addr = 8'h55;
    step();
    checks++;
    if (mem_addr !== 8'h10 || mem_cmd !== 8'h00) begin
      errors++;
      $display("FAIL post_latch: addr %h cmd %h want 10 00",
               mem_addr, mem_cmd);
    end
    step();
    checks++;
    if (m0_done !== 1'b1 || m0_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL post_done: done %b rdata %h want 1 A5",
               m0_done, m0_rdata);
    end
    mem_drive_en = 1'b0;
    step();
  endtask

  task automatic test_noop();
    m0_req = 1'b1; m0_cmd = 8'h07;
    m0_addr = 8'h10; m0_wdata = 8'h5A;
    step();
    checks++;
    if (m0_gnt !== 1'b1 || mem_cmd !== 8'h07) begin
      errors++;
      $display("FAIL noop_gnt: gnt %b cmd %h want 1 07",
               m0_gnt, mem_cmd);
    end
    step();
    checks++;
    if (mem_data !== 8'hFF) begin
      errors++;
      $display("FAIL noop_bus: data %h want FF", mem_data);
    end
    step();
    checks++;
    if (m0_done !== 1'b1 || m0_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL noop_done: done %b rdata %h want 1 A5",
               m0_done, m0_rdata);
    end
    m0_req = 1'b0;
    step();
    checks++;
    if (m0_done !== 1'b0 || m0_gnt !== 1'b0) begin
      errors++;
      $display("FAIL noop_idle: done %b gnt %b want 0 0",
               m0_done, m0_gnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mem_drive_en = 1'b0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
    m0_req = 1'b0; m0_cmd = 8'h00;
    m0_addr = 8'h00; m0_wdata = 8'h00;
    m1_req = 1'b0; m1_cmd = 8'h00;
    m1_addr = 8'h00; m1_wdata = 8'h00;
    rst_n = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_fairness();
    test_reset_abort();
    test_noop();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
